// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x3 keypad scanner.
// Frame results carry the hit position so the top can latch one-hot row/column levels.
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PRESS_DB = 2'd1,
        HELD     = 2'd2,
        REL_DB   = 2'd3
    } kp_state_e;

    localparam logic [3:0] KEY_STAR = 4'hA;
    localparam logic [3:0] KEY_HASH = 4'hB;

    typedef struct packed {
        logic       none;
        logic       key;
        logic       multi;
        logic [3:0] code;
        logic [1:0] row;
        logic [1:0] col;
    } frame_res_t;

    function automatic logic [3:0] rc_to_code(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] c;
        if (row == 2'd3) begin
            case (col)
                2'd0:    c = KEY_STAR;
                2'd1:    c = 4'd0;
                default: c = KEY_HASH;
            endcase
        end else begin
            c = 4'({2'b00, row} * 4'd3 + {2'b00, col} + 4'd1);
        end
        return c;
    endfunction

endpackage

// File: rtl/keypad_frame_sampler.sv
// Row synchroniser, column scan sequencer and per-frame hit accumulation.
// frame_done and res are valid together in the cycle the column index wraps 2 -> 0.
module keypad_frame_sampler
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row_n,
    output logic [2:0] col_drive_n,
    output logic       frame_done,
    output frame_res_t res
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);

    logic [3:0]    sync1_q, sync2_q;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [1:0]    col_q, col_d;
    logic [1:0]    hits_q, hits_d;
    logic [1:0]    hrow_q, hrow_d;
    logic [1:0]    hcol_q, hcol_d;

    logic       sample;
    logic [3:0] lows;
    logic [2:0] n_low, sum;
    logic [1:0] low_idx, tot, res_row, res_col;

    always_comb begin
        sample  = (dwell_q == DWELL_LAST);
        lows    = ~sync2_q;
        n_low   = 3'(lows[0]) + 3'(lows[1]) + 3'(lows[2]) + 3'(lows[3]);
        low_idx = 2'd0;
        for (int r = 3; r >= 0; r--) begin
            if (lows[r]) low_idx = 2'(r);
        end
        // hit count saturates at 2: anything beyond one hit is a ghost frame
        sum = 3'(hits_q) + n_low;
        tot = (sum >= 3'd2) ? 2'd2 : sum[1:0];

        frame_done = sample && (col_q == 2'd2);
        dwell_d    = sample ? '0 : dwell_q + DW'(1);
        col_d      = col_q;
        if (sample) col_d = (col_q == 2'd2) ? 2'd0 : col_q + 2'd1;

        hits_d = hits_q;
        hrow_d = hrow_q;
        hcol_d = hcol_q;
        if (sample) begin
            hits_d = frame_done ? 2'd0 : tot;
            if (hits_q == 2'd0 && n_low == 3'd1) begin
                hrow_d = low_idx;
                hcol_d = col_q;
            end
        end

        res_row   = (hits_q == 2'd0) ? low_idx : hrow_q;
        res_col   = (hits_q == 2'd0) ? col_q : hcol_q;
        res.none  = (tot == 2'd0);
        res.key   = (tot == 2'd1);
        res.multi = (tot == 2'd2);
        res.row   = res_row;
        res.col   = res_col;
        res.code  = rc_to_code(res_row, res_col);

        col_drive_n = ~(3'b001 << col_q);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 4'hF;
            sync2_q <= 4'hF;
            dwell_q <= '0;
            col_q   <= 2'd0;
            hits_q  <= 2'd0;
            hrow_q  <= 2'd0;
            hcol_q  <= 2'd0;
        end else begin
            sync1_q <= row_n;
            sync2_q <= sync1_q;
            dwell_q <= dwell_d;
            col_q   <= col_d;
            hits_q  <= hits_d;
            hrow_q  <= hrow_d;
            hcol_q  <= hcol_d;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x3 keypad scanner top: frame-level debounce FSM producing one event per press.
// Ghost (multi-hit) frames count as "no key" and never start a press.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row_n,
    output logic [2:0] col_drive_n,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic       key_held,
    output logic [3:0] key_row,
    output logic [2:0] key_col
);

    localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [CW-1:0] DB_MAX = CW'(DEBOUNCE_FRAMES);

    logic       frame_done;
    frame_res_t res;

    keypad_frame_sampler #(.SCAN_DIV(SCAN_DIV)) u_sampler (
        .clk        (clk),
        .reset      (reset),
        .row_n      (row_n),
        .col_drive_n(col_drive_n),
        .frame_done (frame_done),
        .res        (res)
    );

    kp_state_e     state_q, state_d;
    logic [CW-1:0] db_cnt_q, db_cnt_d;
    logic [CW-1:0] rel_cnt_q, rel_cnt_d;
    logic          prev_key_q, prev_key_d;
    logic [3:0]    prev_code_q, prev_code_d;
    logic [3:0]    cand_q, cand_d;
    logic          key_valid_q, key_valid_d;
    logic [3:0]    key_code_q, key_code_d;
    logic [3:0]    key_row_q, key_row_d;
    logic [2:0]    key_col_q, key_col_d;

    logic cur_key, same, is_cand, accept, clear, load_cand;

    always_comb begin
        cur_key = res.key && !res.multi && !res.none;
        same    = (cur_key == prev_key_q) && (!cur_key || res.code == prev_code_q);
        is_cand = cur_key && (res.code == cand_q);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (frame_done) begin
            case (state_q)
                IDLE:     if (cur_key) state_d = PRESS_DB;
                PRESS_DB: begin
                    if (!is_cand)               state_d = IDLE;
                    else if (db_cnt_d == DB_MAX) state_d = HELD;
                end
                HELD:     if (!is_cand) state_d = REL_DB;
                REL_DB: begin
                    if (is_cand)                             state_d = HELD;
                    else if (rel_cnt_q + CW'(1) == DB_MAX)   state_d = IDLE;
                end
                default:  state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        key_held  = (state_q == HELD) || (state_q == REL_DB);
        accept    = frame_done && (state_q == PRESS_DB) && (state_d == HELD);
        clear     = frame_done && (state_q == REL_DB) && (state_d == IDLE);
        load_cand = frame_done && (state_q == IDLE) && cur_key;
    end

    // debounce counter tracks runs of identical frame results, independent of state
    always_comb begin
        db_cnt_d    = db_cnt_q;
        prev_key_d  = prev_key_q;
        prev_code_d = prev_code_q;
        rel_cnt_d   = rel_cnt_q;
        if (frame_done) begin
            db_cnt_d    = same ? ((db_cnt_q == DB_MAX) ? DB_MAX : db_cnt_q + CW'(1)) : CW'(1);
            prev_key_d  = cur_key;
            prev_code_d = res.code;
            if (state_q == HELD && !is_cand)        rel_cnt_d = CW'(1);
            else if (state_q == REL_DB && !is_cand) rel_cnt_d = rel_cnt_q + CW'(1);
            else                                    rel_cnt_d = '0;
        end

        cand_d      = load_cand ? res.code : cand_q;
        key_valid_d = accept;
        key_code_d  = accept ? cand_q : key_code_q;
        key_row_d   = accept ? (4'b0001 << res.row) : (clear ? 4'b0000 : key_row_q);
        key_col_d   = accept ? (3'b001 << res.col) : (clear ? 3'b000 : key_col_q);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            db_cnt_q    <= '0;
            rel_cnt_q   <= '0;
            prev_key_q  <= 1'b0;
            prev_code_q <= 4'd0;
            cand_q      <= 4'd0;
            key_valid_q <= 1'b0;
            key_code_q  <= 4'd0;
            key_row_q   <= 4'd0;
            key_col_q   <= 3'd0;
        end else begin
            db_cnt_q    <= db_cnt_d;
            rel_cnt_q   <= rel_cnt_d;
            prev_key_q  <= prev_key_d;
            prev_code_q <= prev_code_d;
            cand_q      <= cand_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            key_row_q   <= key_row_d;
            key_col_q   <= key_col_d;
        end
    end

    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;
    assign key_row   = key_row_q;
    assign key_col   = key_col_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench: a physical keypad model drives row_n from col_drive_n and a
// frame-level reference (result history + press/release rules) predicts every output.
module tb_keypad_scanner;

    localparam int SD = 4;
    localparam int DB = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] row_n;
    logic [2:0] col_drive_n;
    logic       key_valid, key_held;
    logic [3:0] key_code, key_row;
    logic [2:0] key_col;

    always #5 clk = ~clk;

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_FRAMES(DB)) dut (
        .clk        (clk),
        .reset      (reset),
        .row_n      (row_n),
        .col_drive_n(col_drive_n),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .key_held   (key_held),
        .key_row    (key_row),
        .key_col    (key_col)
    );

    // pressed bit index = row*3 + col
    logic [11:0] pressed = '0;
    always_comb begin
        row_n = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 3; c++)
                if (pressed[r*3+c] && !col_drive_n[c]) row_n[r] = 1'b0;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [3:0] codes [12] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'hA, 4'd0, 4'hB};

    // reference model state
    int         hist[$];
    bit         m_held, m_pend, m_rel;
    int         m_cand, m_relcnt;
    bit         e_vld;
    logic [3:0] e_code, e_row;
    logic [2:0] e_col;

    logic [11:0] frame_keys [12];
    int cyc = 0;
    int vld_seen = 0;
    int first_vld = -1;

    function automatic logic [11:0] kb(input int idx);
        logic [11:0] one;
        one = 12'd1;
        return one << idx;
    endfunction

    function automatic void m_reset();
        hist.delete();
        m_held = 0; m_pend = 0; m_rel = 0; m_cand = -1; m_relcnt = 0;
        e_vld = 0; e_code = '0; e_row = '0; e_col = '0;
    endfunction

    // column c is read from the keypad state two cycles before its dwell ends
    function automatic int frame_result();
        int hits = 0;
        int key  = -1;
        for (int c = 0; c < 3; c++) begin
            logic [11:0] k;
            k = frame_keys[1 + 4*c];
            for (int r = 0; r < 4; r++)
                if (k[r*3+c]) begin hits++; key = r*3 + c; end
        end
        return (hits == 1) ? key : -1;
    endfunction

    function automatic int streak();
        int n = 0;
        int last = hist[hist.size()-1];
        for (int i = hist.size() - 1; i >= 0; i--) begin
            if (hist[i] != last) break;
            n++;
        end
        return (n > DB) ? DB : n;
    endfunction

    function automatic void m_frame_end();
        int res, s;
        res = frame_result();
        hist.push_back(res);
        if (hist.size() > 8) void'(hist.pop_front());
        s = streak();
        if (m_rel) begin
            if (res == m_cand) m_rel = 0;
            else begin
                m_relcnt++;
                if (m_relcnt >= DB) begin m_rel = 0; m_held = 0; e_row = '0; e_col = '0; end
            end
        end else if (m_held) begin
            if (res != m_cand) begin m_rel = 1; m_relcnt = 1; end
        end else if (m_pend) begin
            if (res != m_cand) m_pend = 0;
            else if (s >= DB) begin
                m_pend = 0; m_held = 1; e_vld = 1;
                e_code = codes[res];
                e_row  = 4'(1 << (res / 3));
                e_col  = 3'(1 << (res % 3));
            end
        end else if (res >= 0) begin
            m_pend = 1; m_cand = res;
        end
    endfunction

    task automatic chk_outs(input logic [2:0] ecd);
        chk("vld",    key_valid,   e_vld);
        chk("held",   key_held,    m_held);
        chk("code",   key_code,    e_code);
        chk("row",    key_row,     e_row);
        chk("col",    key_col,     e_col);
        chk("coldrv", col_drive_n, ecd);
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            logic [2:0] one3;
            pressed = frame_keys[i];
            @(posedge clk);
            e_vld = 0;
            cyc++;
            if (i == 11) m_frame_end();
            @(negedge clk);
            if (key_valid) begin
                vld_seen++;
                if (first_vld < 0) first_vld = cyc;
            end
            one3 = 3'b001;
            chk_outs(~(one3 << (((i + 1) % 12) / 4)));
        end
    endtask

    task automatic frames(input logic [11:0] k, input int n);
        for (int j = 0; j < 12; j++) frame_keys[j] = k;
        repeat (n) run_cycles(12);
    endtask

    // called at a negedge; reset takes effect without a clock edge
    task automatic do_reset();
        reset = 1'b0;
        #1;
        m_reset();
        chk_outs(3'b110);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        cyc = 0;
    endtask

    initial begin
        int v0, c0, sel;
        logic [11:0] cur;
        reset = 1'b0;
        m_reset();
        @(negedge clk);
        do_reset();

        // idle scan
        frames('0, 9);
        chk("idle_novld", vld_seen, 0);

        // '5' held from frame start
        v0 = vld_seen; c0 = cyc; first_vld = -1;
        frames(kb(4), 5);
        chk("n5", vld_seen - v0, 1);
        chk("lat5", (first_vld >= 0 && first_vld - c0 <= 51), 1);
        chk("row5", key_row, 4'b0010);
        frames('0, 4);

        // bouncing '*' then stable
        v0 = vld_seen;
        for (int f = 0; f < 5; f++) begin
            for (int j = 0; j < 12; j++)
                frame_keys[j] = (((12*f + j + 5) / 7) % 2 != 0) ? kb(9) : 12'd0;
            run_cycles(12);
        end
        chk("bnc_quiet", vld_seen - v0, 0);
        frames(kb(9), 4);
        chk("bnc_code", key_code, 4'hA);
        frames('0, 4);
        chk("bnc_rel", key_held, 0);

        // '1' and '9' together, then '9' released
        v0 = vld_seen;
        frames(kb(0) | kb(8), 4);
        chk("multi_quiet", vld_seen - v0, 0);
        frames(kb(0), 4);
        chk("multi_n", vld_seen - v0, 1);
        chk("multi_code", key_code, 4'd1);
        frames('0, 4);

        // '#' with a one-frame release glitch, then full release and re-press
        v0 = vld_seen;
        frames(kb(11), 4);
        frames('0, 1);
        frames(kb(11), 2);
        chk("glitch_n", vld_seen - v0, 1);
        chk("glitch_held", key_held, 1);
        frames('0, 4);
        frames(kb(11), 4);
        chk("hash_n", vld_seen - v0, 2);
        chk("hash_code", key_code, 4'hB);
        frames('0, 4);

        // reset mid-PRESS_DB, key kept down
        frames(kb(4), 1);
        run_cycles(5);
        do_reset();
        v0 = vld_seen;
        frames(kb(4), 4);
        chk("rst_pd_n", vld_seen - v0, 1);
        // reset mid-HELD
        run_cycles(7);
        do_reset();
        v0 = vld_seen;
        frames(kb(4), 2);
        chk("rst_h_quiet", vld_seen - v0, 0);
        frames(kb(4), 2);
        chk("rst_h_n", vld_seen - v0, 1);
        frames('0, 4);

        // randomized frame sequences with occasional mid-frame changes
        cur = '0;
        for (int f = 0; f < 80; f++) begin
            sel = $urandom_range(99);
            if (sel < 40)      cur = cur;
            else if (sel < 65) cur = '0;
            else if (sel < 90) cur = kb($urandom_range(11));
            else               cur = kb($urandom_range(11)) | kb($urandom_range(11));
            for (int j = 0; j < 12; j++) frame_keys[j] = cur;
            if ($urandom_range(99) < 15) begin
                int sw;
                logic [11:0] alt;
                sw  = $urandom_range(11, 1);
                alt = ($urandom_range(1) != 0) ? kb($urandom_range(11)) : 12'd0;
                for (int j = sw; j < 12; j++) frame_keys[j] = alt;
            end
            run_cycles(12);
        end
        frames('0, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Upstream stage of the safe controller: drives the 4x3 matrix keypad columns and samples its rows.
- Debounces the scanned result and emits one clean key event per physical press.
- Outputs key code plus decoded one-hot row/column levels that feed the safe's keypad-to-BCD logic and digit counter.
- Rejects multi-key (ghost) frames.

Parameters:
- SCAN_DIV, 1000, clk cycles each column is driven (dwell); rows sampled on the last dwell cycle; minimum 4.
- DEBOUNCE_FRAMES, 4, consecutive identical scan frames required to accept a press or a release; minimum 2.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- row_n  in  4  keypad row lines, active-low (pull-ups); bit0 = row1; asynchronous, synchronised internally.
- col_drive_n  out  3  column drive, one-hot-low; bit0 = col1.
- key_valid  out  1  1-cycle pulse on accepted press.
- key_code  out  4  0-9 digits, 4'hA = '*', 4'hB = '#'; valid when key_valid or key_held.
- key_held  out  1  high from key_valid until release accepted.
- key_row  out  4  one-hot row of held key, 0 when not held.
- key_col  out  3  one-hot column of held key, 0 when not held.

Behaviour:
- Keypad map:
  - row1 = 1 2 3
  - row2 = 4 5 6
  - row3 = 7 8 9
  - row4 = * 0 #
  - columns col1..col3 left to right.
- Synchroniser: row_n passes a 2-flop synchroniser before any use.
- Scan sequencing:
  - Dwell counter 0..SCAN_DIV-1, then column index 0 -> 1 -> 2 -> 0.
  - col_drive_n = ~(1 << col index).
  - Rows sampled when dwell counter = SCAN_DIV-1.
- Frame result, evaluated after col index 2 sample: NONE (no low rows), KEY(code) (exactly one row/col hit across the frame), or MULTI (two or more hits, treated as NONE).
- Frame-end cycle: the cycle in which the col index wraps 2 -> 0.
- Debounce counter (width clog2(DEBOUNCE_FRAMES+1)):
  - Increments when the frame result equals the previous frame result.
  - Otherwise reloads to 1.
  - Saturates at DEBOUNCE_FRAMES.
- FSM, updated at frame end only:
  - IDLE:
    - Result KEY(c) -> PRESS_DB, candidate = c.
  - PRESS_DB:
    - Result != KEY(candidate) -> IDLE.
    - Count reaches DEBOUNCE_FRAMES -> HELD.
    - On entering HELD: key_valid = 1 for exactly one cycle (the cycle after frame end); key_code/key_row/key_col latched.
  - HELD:
    - Result != KEY(candidate), including a different key or MULTI -> REL_DB.
  - REL_DB:
    - Result = KEY(candidate) -> HELD, with no new key_valid.
    - DEBOUNCE_FRAMES consecutive non-candidate frames -> IDLE; key_held, key_row and key_col clear.
- key_held = 1 in HELD and REL_DB.
- Rollover: a second key held while the first is held produces no event; only a full release then a press yields a new event.
- Reset (reset = 0, any time, including mid-press):
  - FSM = IDLE, counters = 0, col index = 0, col_drive_n = 3'b110.
  - key_valid = 0, key_held = 0, key_code = 0, key_row = 0, key_col = 0.
  - Synchroniser flops = 4'b1111.
- After release of reset: a key already held is treated as a fresh press and needs a full debounce.
- Worst-case press latency: 2 sync cycles + (DEBOUNCE_FRAMES+1) frames + 1 cycle, where a frame = 3*SCAN_DIV cycles.

Decomposition:
- Shared package keypad_pkg holds:
  - FSM state enum: IDLE, PRESS_DB, HELD, REL_DB.
  - Key code constants: KEY_STAR = 4'hA, KEY_HASH = 4'hB.
  - Row/col-to-code lookup function.
- One sub-module, keypad_frame_sampler: synchroniser, dwell/column counters, and per-frame hit accumulation. Outputs frame_done plus result {none, key, multi, code}.
- FSM and debounce logic stay in the top.

Test Plan:
- Sim parameters: SCAN_DIV = 4, DEBOUNCE_FRAMES = 3, so frame = 12 cycles.
- Reset, then idle 100 cycles -> col_drive_n cycles 110, 101, 011 every 4 cycles; key_valid never asserts; all outputs 0.
- Hold '5' (row2 low while col2 driven) from cycle 0 -> exactly one key_valid pulse within 2 + 4*12 + 1 = 51 cycles; key_code = 5, key_row = 4'b0010, key_col = 3'b010, key_held = 1.
- Bounce: toggle '*' every 7 cycles for 60 cycles, then hold stable -> no pulse during bounce; one pulse with key_code = 4'hA after stable debounce; release -> key_held drops after 3 clean frames.
- Hold '1' and '9' together from IDLE -> no key_valid. Release '9' -> single pulse, key_code = 1.
- Press '#', let it be accepted, glitch release for 1 frame -> no second pulse, key_held stays 1. Full release then re-press '#' -> second pulse with key_code = 4'hB.
- Assert reset mid-PRESS_DB and mid-HELD -> all outputs 0 asynchronously. Keep key held through deassertion -> new pulse only after full debounce.
